// File: rtl/regbank_pkg.sv
// Shared constants, FSM state encoding and buffer entry layout for the
// register-bank dump reader.
package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Register indices wrap at the bank size (ptr+1 at index 31 becomes 0).
  function automatic logic [ADDR_W-1:0] wrapIdx(input int unsigned value);
    return ADDR_W'(value % NUM_REGS);
  endfunction

endpackage

// File: rtl/regbank_dump_reader_if.sv
// Bank read-port and trace-stream signals between the dump reader (master)
// and the register bank / debug sink (slave).
interface regbank_dump_reader_if;
  import regbank_pkg::*;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;

  modport master (
    output rd_addr1, rd_addr2, out_valid, out_index, out_data,
    input  rd_data1, rd_data2, out_ready
  );

  modport slave (
    input  rd_addr1, rd_addr2, out_valid, out_index, out_data,
    output rd_data1, rd_data2, out_ready
  );

endinterface

// File: rtl/regbank_dump_buf.sv
// Two-entry capture buffer: loaded in one shot from both bank read ports,
// then drained one entry per pop, entry0 before entry1.
module regbank_dump_buf
  import regbank_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   flush_i,
  input  logic   load_i,
  input  entry_t entry0_i,
  input  entry_t entry1_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   headIsLast_o
);

  entry_t entry0_q, entry0_d;
  entry_t entry1_q, entry1_d;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (flush_i) begin
      entry0_d = '0;
      entry1_d = '0;
    end else if (load_i) begin
      entry0_d = entry0_i;
      entry1_d = entry1_i;
    end else if (pop_i) begin
      if (entry0_q.valid) begin
        entry0_d.valid = 1'b0;
      end else begin
        entry1_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  // Exactly one valid entry left means the current head is the final one.
  assign head_o       = entry0_q.valid ? entry0_q : entry1_q;
  assign headIsLast_o = entry0_q.valid ^ entry1_q.valid;

endmodule

// File: rtl/regbank_dump_reader.sv
// Debug reader that walks a register range two indices per bank read and
// streams each register out as an (index, data) valid/ready beat.
module regbank_dump_reader
  import regbank_pkg::*;
#(
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     first_reg,
  input  logic [ADDR_W-1:0]     last_reg,
  output logic                  busy,
  output logic                  done,
  regbank_dump_reader_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] ptrNext;
  logic              bufLoad, bufPop, bufFlush;
  entry_t            entry0, entry1, head;
  logic              headIsLast;
  logic              handshake;

  assign ptrNext = wrapIdx(32'(ptr_q) + 32'd1);

  // Entry1 is dropped when ptr already sits on the last index, which also
  // hides the harmless 31 -> 0 wrap of ptr+1.
  always_comb begin
    entry0       = '0;
    entry1       = '0;
    entry0.valid = 1'b1;
    entry0.index = ptr_q;
    entry0.data  = bus.rd_data1;
    entry1.valid = ({1'b0, ptr_q} < {1'b0, last_q});
    entry1.index = ptrNext;
    entry1.data  = bus.rd_data2;
  end

  regbank_dump_buf u_buf (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (bufFlush),
    .load_i       (bufLoad),
    .entry0_i     (entry0),
    .entry1_i     (entry1),
    .pop_i        (bufPop),
    .head_o       (head),
    .headIsLast_o (headIsLast)
  );

  assign handshake = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    last_d   = last_q;
    bufLoad  = 1'b0;
    bufPop   = 1'b0;
    bufFlush = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, first_reg} <= {1'b0, last_reg}) begin
            ptr_d   = first_reg;
            last_d  = last_reg;
            state_d = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        bufLoad = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (handshake) begin
          bufPop = 1'b1;
          if (headIsLast) begin
            if ({1'b0, head.index} == {1'b0, last_q}) begin
              state_d = FIN;
            end else begin
              ptr_d   = wrapIdx(32'(ptr_q) + 32'd2);
              state_d = READ;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort cancels whatever the active state decided, including a beat.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      ptr_d    = ptr_q;
      bufLoad  = 1'b0;
      bufPop   = 1'b0;
      bufFlush = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    bus.rd_addr1  = (state_q == READ) ? ptr_q : '0;
    bus.rd_addr2  = (state_q == READ) ? ptrNext : '0;
    bus.out_valid = (state_q == SEND) && head.valid;
    bus.out_index = bus.out_valid ? head.index : '0;
    bus.out_data  = '0;
    if (bus.out_valid && !(ZERO_REG0 && head.index == '0)) begin
      bus.out_data = head.data;
    end
    busy = (state_q != IDLE);
    done = (state_q == FIN) && !abort;
  end

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Directed bench for regbank_dump_reader: a bank model feeds the read ports
// and a scoreboard queue holds the beats each dump should produce.
module tb_regbank_dump_reader;
  import regbank_pkg::*;

  logic              clock;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic              busy;
  logic              done;

  regbank_dump_reader_if bus();

  regbank_dump_reader #(.ZERO_REG0(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  logic [DATA_W-1:0] bank [NUM_REGS];
  assign bus.rd_data1 = bank[bus.rd_addr1];
  assign bus.rd_data2 = bank[bus.rd_addr2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [36:0] sbQ [$];

  int cyc = 0;
  int startCyc = -10;
  int firstValidCyc = -1;
  int lastBeatCyc = -1;
  int doneCyc = -1;
  int doneCount = 0;
  int beatsSeen = 0;
  int validSeen = 0;
  int busyCycles = 0;
  logic [ADDR_W-1:0] readAddr1 = '0;
  logic [ADDR_W-1:0] readAddr2 = '0;
  logic              stallPending = 1'b0;
  logic [ADDR_W-1:0] prevIndex = '0;
  logic [DATA_W-1:0] prevData = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [36:0] expBeat(input int i);
    logic [DATA_W-1:0] d;
    d = (i == 0) ? 32'h0 : 32'(32'h1000 + i);
    return {5'(i), d};
  endfunction

  // One clock: observe mid-cycle at the falling edge, then step past the
  // rising edge so the caller can drive the next cycle's inputs.
  task automatic tick();
    logic [36:0] exp;
    @(negedge clock);
    cyc++;
    if (!reset) begin
      if (busy) busyCycles++;
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (cyc == startCyc + 1) begin
        readAddr1 = bus.rd_addr1;
        readAddr2 = bus.rd_addr2;
      end
    end
    if (!reset && !abort) begin
      if (bus.out_valid) begin
        validSeen++;
        if (firstValidCyc < 0) firstValidCyc = cyc;
      end
      if (stallPending) begin
        checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("stall_index", 64'(bus.out_index), 64'(prevIndex));
        checkOutput("stall_data", 64'(bus.out_data), 64'(prevData));
      end
      if (bus.out_valid && bus.out_ready) begin
        exp = '1;
        if (sbQ.size() != 0) exp = sbQ.pop_front();
        checkOutput("beat", 64'({bus.out_index, bus.out_data}), 64'(exp));
        beatsSeen++;
        lastBeatCyc = cyc;
      end
      stallPending = bus.out_valid && !bus.out_ready;
      prevIndex = bus.out_index;
      prevData = bus.out_data;
    end else begin
      stallPending = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) sbQ.push_back(expBeat(i));
    first_reg = ADDR_W'(first);
    last_reg = ADDR_W'(last);
    start = 1'b1;
    startCyc = cyc + 1;
    firstValidCyc = -1;
    lastBeatCyc = -1;
    doneCyc = -1;
    doneCount = 0;
    beatsSeen = 0;
    validSeen = 0;
    busyCycles = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(doneCount != 0), 64'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_addr1"}, 64'(bus.rd_addr1), 64'd0);
    checkOutput({tag, "_addr2"}, 64'(bus.rd_addr2), 64'd0);
    checkOutput({tag, "_index"}, 64'(bus.out_index), 64'd0);
    checkOutput({tag, "_data"}, 64'(bus.out_data), 64'd0);
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < NUM_REGS; i++) bank[i] = 32'(32'h1000 + i);
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    first_reg = '0;
    last_reg = '0;
    bus.out_ready = 1'b0;
    @(posedge clock);
    #1;
    tick();
    tick();
    checkResetOutputs("reset");
    reset = 1'b0;
    tick();

    $display("[TB] full dump 0..31, sink always ready");
    bus.out_ready = 1'b1;
    applyStimulus(0, 31);
    waitDone(200, "full_done_seen");
    tick();
    tick();
    checkOutput("full_beats", 64'(beatsSeen), 64'd32);
    checkOutput("full_sb_empty", 64'(sbQ.size()), 64'd0);
    checkOutput("full_done_once", 64'(doneCount), 64'd1);
    checkOutput("full_done_lat", 64'(doneCyc - lastBeatCyc), 64'd1);
    checkOutput("full_first_lat", 64'(firstValidCyc - startCyc), 64'd2);
    checkOutput("full_throughput", 64'(lastBeatCyc - firstValidCyc), 64'd46);

    $display("[TB] single register 5..5");
    applyStimulus(5, 5);
    waitDone(20, "single_done_seen");
    tick();
    checkOutput("single_beats", 64'(beatsSeen), 64'd1);
    checkOutput("single_sb_empty", 64'(sbQ.size()), 64'd0);
    checkOutput("single_addr1", 64'(readAddr1), 64'd5);
    checkOutput("single_addr2", 64'(readAddr2), 64'd6);
    checkOutput("single_done_lat", 64'(doneCyc - lastBeatCyc), 64'd1);

    $display("[TB] empty range 9..3");
    applyStimulus(9, 3);
    waitDone(10, "empty_done_seen");
    tick();
    tick();
    checkOutput("empty_done_cyc", 64'(doneCyc - startCyc), 64'd1);
    checkOutput("empty_no_valid", 64'(validSeen), 64'd0);
    checkOutput("empty_busy_cycles", 64'(busyCycles), 64'd1);

    $display("[TB] range 28..31 with stalling sink");
    applyStimulus(28, 31);
    n = 0;
    k = 0;
    while (doneCount == 0 && n < 100) begin
      bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
      k++;
      tick();
      n++;
    end
    checkOutput("stall_done_seen", 64'(doneCount != 0), 64'd1);
    checkOutput("stall_beats", 64'(beatsSeen), 64'd4);
    checkOutput("stall_sb_empty", 64'(sbQ.size()), 64'd0);
    bus.out_ready = 1'b1;
    tick();

    $display("[TB] abort after third beat");
    applyStimulus(0, 31);
    n = 0;
    while (beatsSeen < 3 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("abort_three_beats", 64'(beatsSeen), 64'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    sbQ.delete();
    doneCount = 0;
    tick();
    tick();
    tick();
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    applyStimulus(2, 3);
    waitDone(20, "abort_restart_done");
    checkOutput("abort_restart_beats", 64'(beatsSeen), 64'd2);
    checkOutput("abort_restart_sb", 64'(sbQ.size()), 64'd0);
    tick();

    $display("[TB] reset mid-send");
    applyStimulus(0, 31);
    n = 0;
    while (beatsSeen < 2 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("midreset_two_beats", 64'(beatsSeen), 64'd2);
    reset = 1'b1;
    tick();
    checkResetOutputs("midreset");
    reset = 1'b0;
    sbQ.delete();
    tick();
    applyStimulus(10, 12);
    waitDone(30, "midreset_restart_done");
    checkOutput("midreset_restart_beats", 64'(beatsSeen), 64'd3);
    checkOutput("midreset_restart_sb", 64'(sbQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
